// File: rtl/key_hit_arbiter.sv
// Shared-timer debounce and round-robin arbiter for N raw mole-hit keys.
// Optional OFFER timeout/discard is enabled by defining KEY_HIT_TIMEOUT_EN.
module key_hit_arbiter #(
    parameter int N_KEYS      = 4,
    parameter int SETTLE_CNT  = 2000000,
    parameter int TIMEOUT_CNT = 1000000,
    parameter int CW          = 21
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic [N_KEYS-1:0]         key,
    input  logic                      hit_ready,
    output logic                      hit_valid,
    output logic [$clog2(N_KEYS)-1:0] hit_idx,
    output logic                      hit_drop,
    output logic                      busy
);

    localparam int IW = $clog2(N_KEYS);

    typedef enum logic [1:0] {IDLE, SETTLE, OFFER} state_t;

    state_t            state;
    logic [N_KEYS-1:0] ks_meta;
    logic [N_KEYS-1:0] ks;
    logic [N_KEYS-1:0] mask;
    logic [N_KEYS-1:0] mask_set;
    logic [N_KEYS-1:0] elig;
    logic [IW-1:0]     cand;
    logic [IW-1:0]     last_grant;
    logic [IW-1:0]     win_idx;
    logic              win_found;
    logic [CW-1:0]     cnt;
    logic              accept;
    logic              drop_now;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, as real hardware does.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ks_meta <= '0;
            ks      <= '0;
        end else begin
            ks_meta <= key;
            ks      <= ks_meta;
        end
    end

    assign elig   = ks & ~mask;
    assign accept = hit_valid & hit_ready;

`ifdef KEY_HIT_TIMEOUT_EN
    // A same-cycle handshake beats the timeout.
    assign drop_now = (state == OFFER) && !hit_ready && (cnt == CW'(TIMEOUT_CNT - 1));
`else
    assign drop_now = 1'b0;
`endif

    // Search starts one past the last granted key and wraps.
    always_comb begin : rr_search
        logic [31:0] rr_pos;
        // NOTE: every variable gets a default first so no path leaves a latch.
        win_found = 1'b0;
        win_idx   = '0;
        rr_pos    = '0;
        for (int k = 1; k <= N_KEYS; k++) begin
            rr_pos = 32'((int'(last_grant) + k) % N_KEYS);
            if (!win_found && elig[rr_pos[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = rr_pos[IW-1:0];
            end
        end
    end

    always_comb begin
        mask_set = '0;
        if (state == OFFER && (accept || drop_now))
            mask_set[cand] = 1'b1;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            cand       <= '0;
            cnt        <= '0;
            last_grant <= IW'(N_KEYS - 1);
            mask       <= '0;
            hit_valid  <= 1'b0;
            hit_idx    <= '0;
            hit_drop   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // A released key unmasks; a finished event masks until release.
            mask     <= (mask & ks) | mask_set;
            hit_drop <= drop_now;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        cand  <= win_idx;
                        cnt   <= '0;
                        state <= SETTLE;
                        busy  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (!ks[cand]) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == CW'(SETTLE_CNT - 1)) begin
                        state     <= OFFER;
                        hit_valid <= 1'b1;
                        hit_idx   <= cand;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OFFER: begin
                    if (accept || drop_now) begin
                        hit_valid  <= 1'b0;
                        last_grant <= cand;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end else begin
`ifdef KEY_HIT_TIMEOUT_EN
                        cnt <= cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_hit_arbiter.sv
// Self-checking bench for key_hit_arbiter: directed timing cases plus
// randomized rounds scored against a round-robin event-order model.
module tb_key_hit_arbiter;

    localparam int N  = 4;
    localparam int S  = 4;
    localparam int T  = 8;
    localparam int CW = 8;
    localparam int IW = 2;
`ifdef KEY_HIT_TIMEOUT_EN
    localparam int HOLD = 5;
`else
    localparam int HOLD = 20;
`endif

    logic          clk = 1'b0;
    logic          clr;
    logic [N-1:0]  key;
    logic          hit_ready;
    logic          hit_valid;
    logic [IW-1:0] hit_idx;
    logic          hit_drop;
    logic          busy;

    int n_checks = 0;
    int n_err    = 0;
    int model_last;

    always #5 clk = ~clk;

    key_hit_arbiter #(
        .N_KEYS(N), .SETTLE_CNT(S), .TIMEOUT_CNT(T), .CW(CW)
    ) dut (
        .clk(clk), .clr(clr), .key(key), .hit_ready(hit_ready),
        .hit_valid(hit_valid), .hit_idx(hit_idx), .hit_drop(hit_drop), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output int cycles);
        cycles = 0;
        while (!hit_valid && cycles < budget) begin
            step();
            cycles++;
        end
        check("wait_valid", hit_valid, 1);
    endtask

    // Hold pat, collect completed (accepted or dropped) events, compare order.
    task automatic run_round(input logic [N-1:0] pat, input bit rnd, input string tag);
        int exp_q[$];
        int got_q[$];
        int bad_stable = 0;
        int bad_gap    = 0;
        int last_rise  = -1;
        logic v, r;
        logic [IW-1:0] i;
        for (int k = 1; k <= N; k++) begin
            int p = (model_last + k) % N;
            if (pat[p]) exp_q.push_back(p);
        end
        key = pat;
        for (int c = 0; c < 400; c++) begin
            hit_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            v = hit_valid;
            r = hit_ready;
            i = hit_idx;
            step();
            if (v && r) got_q.push_back(int'(i));
            else if (hit_drop) got_q.push_back(int'(i));
            else if (v && (!hit_valid || hit_idx != i)) bad_stable++;
            if (hit_valid && !v) begin
                if (!rnd && last_rise >= 0 && c - last_rise != S + 2) bad_gap++;
                last_rise = c;
            end
        end
        check($sformatf("%s_count", tag), got_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < got_q.size(); j++)
            check($sformatf("%s_idx%0d", tag, j), got_q[j], exp_q[j]);
        check($sformatf("%s_stable", tag), bad_stable, 0);
        check($sformatf("%s_gap", tag), bad_gap, 0);
        if (exp_q.size() > 0) model_last = exp_q[exp_q.size()-1];
        key = '0;
        hit_ready = 1'b0;
        repeat (4) step();
        check($sformatf("%s_idle", tag), busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, cnt_v, bad, hi, drops, c;

        clr = 1'b1; key = '0; hit_ready = 1'b0;
        model_last = N - 1;
        step(); step();
        check("rst_valid", hit_valid, 0);
        check("rst_idx", hit_idx, 0);
        check("rst_drop", hit_drop, 0);
        check("rst_busy", busy, 0);
        clr = 1'b0;
        step(); step();

        // Single held key: latency, one-cycle event, no repeat while held.
        key = 4'b0001; hit_ready = 1'b1;
        wait_valid(50, lat);
        check("k0_latency", lat, S + 3);
        check("k0_idx", hit_idx, 0);
        step();
        check("k0_one_cycle", hit_valid, 0);
        cnt_v = 0;
        repeat (30) begin step(); if (hit_valid) cnt_v++; end
        check("k0_no_repeat", cnt_v, 0);
        check("k0_busy", busy, 0);
        model_last = 0;
        key = '0;
        repeat (4) step();

        // Bounce on key 2, then a clean press.
        key = 4'b0100;
        step(); step();
        key = '0;
        hi = 0; cnt_v = 0;
        repeat (12) begin step(); if (busy) hi++; if (hit_valid) cnt_v++; end
        check("bounce_busy_seen", hi > 0, 1);
        check("bounce_no_valid", cnt_v, 0);
        check("bounce_busy_low", busy, 0);
        key = 4'b0100;
        wait_valid(50, lat);
        check("k2_latency", lat, S + 3);
        check("k2_idx", hit_idx, 2);
        step();
        model_last = 2;
        key = '0;
        repeat (4) step();

        // Two keys held: round-robin order and back-to-back spacing.
        run_round(4'b0101, 1'b0, "rr_a");
        run_round(4'b0101, 1'b0, "rr_b");

        // Pending event held stable under backpressure after key release.
        key = 4'b0010; hit_ready = 1'b0;
        wait_valid(50, lat);
        check("bp_idx", hit_idx, 1);
        key = '0;
        bad = 0;
        repeat (HOLD) begin step(); if (!hit_valid || hit_idx != 1) bad++; end
        check("bp_stable", bad, 0);
        hit_ready = 1'b1;
        step();
        check("bp_done", hit_valid, 0);
        hit_ready = 1'b0;
        model_last = 1;
        repeat (4) step();

        // Asynchronous clear in mid-SETTLE of key 3.
        key = 4'b1000; hit_ready = 1'b1;
        c = 0;
        while (!busy && c < 20) begin step(); c++; end
        check("clr_busy_before", busy, 1);
        step(); step();
        clr = 1'b1;
        #1;
        check("clr_valid", hit_valid, 0);
        check("clr_busy", busy, 0);
        check("clr_idx", hit_idx, 0);
        check("clr_drop", hit_drop, 0);
        step(); step();
        clr = 1'b0;
        wait_valid(50, lat);
        check("clr_latency", lat, S + 3);
        check("clr_k3_idx", hit_idx, 3);
        step();
        model_last = 3;
        key = '0; hit_ready = 1'b0;
        repeat (4) step();

        // OFFER with hit_ready low: timeout discard or indefinite wait.
        key = 4'b0001; hit_ready = 1'b0;
        wait_valid(50, lat);
        check("to_idx", hit_idx, 0);
        key = '0;
`ifdef KEY_HIT_TIMEOUT_EN
        hi = 1; c = 0;
        while (hit_valid && c < 50) begin step(); if (hit_valid) hi++; c++; end
        check("to_valid_cycles", hi, T);
        check("to_drop_pulse", hit_drop, 1);
        step();
        check("to_drop_low", hit_drop, 0);
        check("to_valid_low", hit_valid, 0);
`else
        hi = 0; drops = 0;
        repeat (100) begin step(); if (hit_valid) hi++; if (hit_drop) drops++; end
        check("wait_valid_held", hi, 100);
        check("wait_no_drop", drops, 0);
        hit_ready = 1'b1;
        step();
        check("wait_done", hit_valid, 0);
        hit_ready = 1'b0;
`endif
        model_last = 0;
        repeat (4) step();

        // Randomized key sets with random backpressure.
        for (int r = 0; r < 6; r++)
            run_round(N'($urandom_range(1, 15)), 1'b1, $sformatf("rnd%0d", r));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
